// File: rtl/btn_conditioner.sv
// btn_conditioner: multi-channel push-button front end.
// Per channel: SYNC_STAGES-deep input synchroniser, counter debounce,
// optional pair-lock masking (channels 2k/2k+1), registered level/press/
// release outputs and a typematic auto-repeat strobe.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset (0 = reset)
//   btn_in       raw asynchronous button levels, active-high
//   btn_level    debounced, masked level
//   btn_press    1-cycle pulse on btn_level rising
//   btn_release  1-cycle pulse on btn_level falling
//   btn_strobe   1-cycle pulse on press and on every auto-repeat tick
module btn_conditioner #(
  parameter int CHANNELS        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 400000,
  parameter int REPEAT_DELAY    = 20000000,
  parameter int REPEAT_RATE     = 4000000,
  parameter int PAIR_LOCK       = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_strobe
);

  localparam int DCW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = $clog2(RMAX + 1);

  localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  // REPEAT_DELAY=0 never leaves IDLE, so RD_LAST is a don't-care then.
  localparam logic [RCW-1:0] RD_LAST = RCW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RCW-1:0] RR_LAST = RCW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, RATE = 2'd2} rpt_state_e;

  logic [CHANNELS-1:0] db;  // debounced raw level
  logic [CHANNELS-1:0] m;   // after pair-lock masking

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

    // Pair-lock: a channel is hidden while its partner is also held, so
    // releasing one side re-exposes the other as a fresh press.
    if (PAIR_LOCK != 0 && (i ^ 1) < CHANNELS) begin : g_lock
      assign m[i] = db[i] & ~db[i ^ 1];
    end else begin : g_free
      assign m[i] = db[i];
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   db_q;
    logic [DCW-1:0]         dcnt;
    logic                   level_q, press_q, rel_q, stb_q;
    rpt_state_e             state, state_nxt;
    logic [RCW-1:0]         rcnt, rcnt_nxt;
    logic                   tick;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync <= '0;
      else      sync <= {sync[SYNC_STAGES-2:0], btn_in[i]};
    end
    assign s = sync[SYNC_STAGES-1];

    // Any disagreement run shorter than DEBOUNCE_CYCLES is discarded.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        db_q <= 1'b0;
        dcnt <= '0;
      end else if (s == db_q) begin
        dcnt <= '0;
      end else if (dcnt == DC_LAST) begin
        db_q <= s;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
    assign db[i] = db_q;

    // level_q doubles as m_prev for edge detection.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        stb_q   <= 1'b0;
      end else begin
        level_q <= m[i];
        press_q <= m[i] & ~level_q;
        rel_q   <= ~m[i] & level_q;
        stb_q   <= (m[i] & ~level_q) | tick;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= IDLE;
        rcnt  <= '0;
      end else begin
        state <= state_nxt;
        rcnt  <= rcnt_nxt;
      end
    end

    // A masked fall always wins over a due tick: the channel drops to IDLE
    // with no strobe in the release cycle.
    always_comb begin
      state_nxt = state;
      rcnt_nxt  = rcnt;
      tick      = 1'b0;
      unique case (state)
        IDLE: begin
          if (REPEAT_DELAY > 0 && m[i] && !level_q) begin
            state_nxt = DELAY;
            rcnt_nxt  = '0;
          end
        end
        DELAY: begin
          if (!m[i]) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == RD_LAST) begin
            tick      = 1'b1;
            rcnt_nxt  = '0;
            state_nxt = RATE;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        RATE: begin
          if (!m[i]) begin
            state_nxt = IDLE;
            rcnt_nxt  = '0;
          end else if (rcnt == RR_LAST) begin
            tick     = 1'b1;
            rcnt_nxt = '0;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
    assign btn_strobe[i]  = stb_q;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner. Three instances share clk/rst/btn_in:
//   0: pair-lock, repeat delay 10 / rate 3
//   1: no pair-lock, same repeat timing
//   2: pair-lock, repeat disabled (REPEAT_DELAY=0)
// Stimulus rows carry the expected output snapshot of one instance at a
// later cycle; those are queued when the row is driven and compared when
// the cycle counter reaches them. Strobe/press counts per window are also
// compared.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn_in = 2'b00;
  logic [1:0] lvl [3];
  logic [1:0] prs [3];
  logic [1:0] rel [3];
  logic [1:0] stb [3];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  btn_conditioner #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10), .REPEAT_RATE(3), .PAIR_LOCK(1)) u_lock (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(lvl[0]),
    .btn_press(prs[0]), .btn_release(rel[0]), .btn_strobe(stb[0]));

  btn_conditioner #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10), .REPEAT_RATE(3), .PAIR_LOCK(0)) u_free (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(lvl[1]),
    .btn_press(prs[1]), .btn_release(rel[1]), .btn_strobe(stb[1]));

  btn_conditioner #(.CHANNELS(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(0), .REPEAT_RATE(3), .PAIR_LOCK(1)) u_norep (
    .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(lvl[2]),
    .btn_press(prs[2]), .btn_release(rel[2]), .btn_strobe(stb[2]));

  typedef struct {
    int         at;
    logic [1:0] btn;
    int         dut;
    int         chk;
    logic [7:0] outs;  // {level, press, release, strobe}
  } vec_t;

  typedef struct {
    int         chk;
    int         dut;
    logic [7:0] outs;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   c_stb [3][2];
  int   c_prs [3][2];
  int   c_lvl [3][2];
  int   s_stb [3][2];
  int   s_prs [3][2];
  int   s_lvl [3][2];

  function automatic void row(int at, logic [1:0] btn, int dut, int chk,
                              logic [1:0] l, logic [1:0] p, logic [1:0] r, logic [1:0] s);
    vec_t v;
    v.at = at; v.btn = btn; v.dut = dut; v.chk = chk; v.outs = {l, p, r, s};
    tbl.push_back(v);
  endfunction

  task automatic expect_at(int chk, int dut, logic [1:0] l, logic [1:0] p,
                           logic [1:0] r, logic [1:0] s);
    exp_t e;
    e.chk = chk; e.dut = dut; e.outs = {l, p, r, s};
    sb.push_back(e);
  endtask

  task automatic cmp(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // One clock: sample at the falling edge, tally pulses, retire due checks.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < 2; c++) begin
        if (stb[d][c]) c_stb[d][c]++;
        if (prs[d][c]) c_prs[d][c]++;
        if (lvl[d][c]) c_lvl[d][c]++;
      end
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].chk == cyc) begin
        cmp($sformatf("dut%0d outs{lvl,prs,rel,stb} @%0d", sb[i].dut, cyc),
            int'({lvl[sb[i].dut], prs[sb[i].dut], rel[sb[i].dut], stb[sb[i].dut]}),
            int'(sb[i].outs));
        sb.delete(i);
      end
  endtask

  task automatic wait_until(int n);
    while (cyc < n) tick();
  endtask

  task automatic run_tbl(int lo, int hi);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].at >= lo && tbl[i].at <= hi) begin
        wait_until(tbl[i].at);
        btn_in = tbl[i].btn;
        expect_at(tbl[i].chk, tbl[i].dut, tbl[i].outs[7:6], tbl[i].outs[5:4],
                  tbl[i].outs[3:2], tbl[i].outs[1:0]);
      end
  endtask

  task automatic snap();
    s_stb = c_stb; s_prs = c_prs; s_lvl = c_lvl;
  endtask

  task automatic chk_cnt(string tag, int d, int c, int req_stb, int req_prs);
    cmp($sformatf("%s strobes dut%0d ch%0d", tag, d, c), c_stb[d][c] - s_stb[d][c], req_stb);
    cmp($sformatf("%s presses dut%0d ch%0d", tag, d, c), c_prs[d][c] - s_prs[d][c], req_prs);
  endtask

  localparam int A = 10;   // single hold, repeats, release/tick collision
  localparam int G = 60;   // glitches
  localparam int C = 90;   // pair-lock vs independent
  localparam int E = 170;  // reset mid-RATE
  localparam int F = E + 24;

  initial begin
    // Scenario: hold ch0, repeat at +10,+13,+16.., release lands on a tick.
    row(A,      2'b01, 0, A+6,  2'b00, 2'b00, 2'b00, 2'b00);
    row(A,      2'b01, 0, A+7,  2'b01, 2'b01, 2'b00, 2'b01);
    row(A,      2'b01, 1, A+7,  2'b01, 2'b01, 2'b00, 2'b01);
    row(A,      2'b01, 2, A+7,  2'b01, 2'b01, 2'b00, 2'b01);
    row(A,      2'b01, 0, A+8,  2'b01, 2'b00, 2'b00, 2'b00);
    row(A,      2'b01, 0, A+16, 2'b01, 2'b00, 2'b00, 2'b00);
    row(A,      2'b01, 0, A+17, 2'b01, 2'b00, 2'b00, 2'b01);
    row(A,      2'b01, 2, A+17, 2'b01, 2'b00, 2'b00, 2'b00);
    row(A,      2'b01, 0, A+20, 2'b01, 2'b00, 2'b00, 2'b01);
    row(A,      2'b01, 0, A+23, 2'b01, 2'b00, 2'b00, 2'b01);
    row(A+25,   2'b00, 0, A+29, 2'b01, 2'b00, 2'b00, 2'b01);
    row(A+25,   2'b00, 0, A+31, 2'b01, 2'b00, 2'b00, 2'b00);
    row(A+25,   2'b00, 0, A+32, 2'b00, 2'b00, 2'b01, 2'b00);
    row(A+25,   2'b00, 1, A+32, 2'b00, 2'b00, 2'b01, 2'b00);
    row(A+25,   2'b00, 2, A+32, 2'b00, 2'b00, 2'b01, 2'b00);
    row(A+25,   2'b00, 0, A+33, 2'b00, 2'b00, 2'b00, 2'b00);
    // Scenario: ch0 held, ch1 joins, ch0 leaves.
    row(C,      2'b01, 0, C+7,  2'b01, 2'b01, 2'b00, 2'b01);
    row(C,      2'b01, 1, C+7,  2'b01, 2'b01, 2'b00, 2'b01);
    row(C,      2'b01, 0, C+17, 2'b01, 2'b00, 2'b00, 2'b01);
    row(C+12,   2'b11, 0, C+18, 2'b01, 2'b00, 2'b00, 2'b00);
    row(C+12,   2'b11, 0, C+19, 2'b00, 2'b00, 2'b01, 2'b00);
    row(C+12,   2'b11, 1, C+19, 2'b11, 2'b10, 2'b00, 2'b10);
    row(C+12,   2'b11, 2, C+19, 2'b00, 2'b00, 2'b01, 2'b00);
    row(C+12,   2'b11, 0, C+20, 2'b00, 2'b00, 2'b00, 2'b00);
    row(C+12,   2'b11, 1, C+20, 2'b11, 2'b00, 2'b00, 2'b01);
    row(C+30,   2'b10, 0, C+36, 2'b00, 2'b00, 2'b00, 2'b00);
    row(C+30,   2'b10, 0, C+37, 2'b10, 2'b10, 2'b00, 2'b10);
    row(C+30,   2'b10, 1, C+37, 2'b10, 2'b00, 2'b01, 2'b00);
    row(C+30,   2'b10, 1, C+38, 2'b10, 2'b00, 2'b00, 2'b10);
    row(C+30,   2'b10, 0, C+46, 2'b10, 2'b00, 2'b00, 2'b00);
    row(C+30,   2'b10, 0, C+47, 2'b10, 2'b00, 2'b00, 2'b10);
    row(C+55,   2'b00, 0, C+62, 2'b00, 2'b00, 2'b10, 2'b00);
    row(C+55,   2'b00, 1, C+62, 2'b00, 2'b00, 2'b10, 2'b00);

    // Reset from time 0 with a real falling edge on rst.
    #1 rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      cmp($sformatf("reset outs dut%0d", d),
          int'({lvl[d], prs[d], rel[d], stb[d]}), 0);
    wait_until(2);
    rst = 1'b1;

    snap();
    run_tbl(A, A+30);
    wait_until(A+45);
    chk_cnt("hold", 0, 0, 6, 1);
    chk_cnt("hold", 1, 0, 6, 1);
    chk_cnt("hold", 2, 0, 1, 1);
    chk_cnt("hold", 0, 1, 0, 0);

    // Glitch runs of 3 stable cycles never reach the 4-cycle threshold.
    snap();
    wait_until(G);   btn_in = 2'b01;
    wait_until(G+3); btn_in = 2'b00;
    wait_until(G+4); btn_in = 2'b01;
    for (int d = 0; d < 3; d++) begin
      expect_at(G+9,  d, 2'b00, 2'b00, 2'b00, 2'b00);
      expect_at(G+12, d, 2'b00, 2'b00, 2'b00, 2'b00);
    end
    wait_until(G+7); btn_in = 2'b00;
    wait_until(G+25);
    for (int d = 0; d < 3; d++) begin
      chk_cnt("glitch", d, 0, 0, 0);
      cmp($sformatf("glitch level cycles dut%0d", d), c_lvl[d][0] - s_lvl[d][0], 0);
    end

    snap();
    run_tbl(C, C+60);
    wait_until(C+75);
    chk_cnt("pair", 0, 0, 2, 1);
    chk_cnt("pair", 0, 1, 6, 1);
    chk_cnt("pair", 1, 0, 8, 1);
    chk_cnt("pair", 1, 1, 12, 1);
    chk_cnt("pair", 2, 0, 1, 1);
    chk_cnt("pair", 2, 1, 1, 1);

    // Reset in the middle of RATE, button kept held through it.
    snap();
    wait_until(E); btn_in = 2'b01;
    expect_at(E+7,  0, 2'b01, 2'b01, 2'b00, 2'b01);
    expect_at(E+20, 0, 2'b01, 2'b00, 2'b00, 2'b01);
    expect_at(E+21, 0, 2'b01, 2'b00, 2'b00, 2'b00);
    for (int d = 0; d < 2; d++)
      for (int k = 22; k <= 24; k++)
        expect_at(E+k, d, 2'b00, 2'b00, 2'b00, 2'b00);
    wait_until(E+21);
    #2 rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++)
      cmp($sformatf("async reset outs dut%0d", d),
          int'({lvl[d], prs[d], rel[d], stb[d]}), 0);
    wait_until(F);
    rst = 1'b1;
    expect_at(F+6,  0, 2'b00, 2'b00, 2'b00, 2'b00);
    expect_at(F+7,  0, 2'b01, 2'b01, 2'b00, 2'b01);
    expect_at(F+7,  2, 2'b01, 2'b01, 2'b00, 2'b01);
    expect_at(F+17, 0, 2'b00, 2'b00, 2'b01, 2'b00);
    wait_until(F+10); btn_in = 2'b00;
    wait_until(F+25);
    chk_cnt("reset", 0, 0, 4, 2);
    chk_cnt("reset", 1, 0, 4, 2);
    chk_cnt("reset", 2, 0, 2, 2);

    cmp("scoreboard entries left", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
